// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM-to-WB payload, commits results to the
// 32x32 register file, serves decode's two read ports with bypass, and drives trace/status.
module wb_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_signal_valid,
  input  logic [69:0] MEM_signal,
  output logic        WB_allowin,
  input  logic [4:0]  rf_raddr1,
  input  logic [4:0]  rf_raddr2,
  output logic [31:0] rf_rdata1,
  output logic [31:0] rf_rdata2,
  output logic        WB_valid,
  output logic [4:0]  WB_dest,
  output logic [31:0] WB_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  logic        wb_valid;
  logic [69:0] wb_signal;
  logic        wb_readygo;
  logic        wb_live;
  logic [31:0] pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] final_result;
  logic        rf_wen;
  logic [31:0] regs [32];

  assign wb_readygo   = 1'b1;
  assign pc           = wb_signal[69:38];
  assign rf_we        = wb_signal[37];
  assign rf_waddr     = wb_signal[36:32];
  assign final_result = wb_signal[31:0];

  // Reset masks the held instruction so an in-flight write is dropped without trace
  assign wb_live    = wb_valid && !reset;
  assign rf_wen     = wb_live && rf_we && (rf_waddr != 5'd0);
  assign WB_allowin = !reset && (!wb_valid || wb_readygo);

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
    end else if (WB_allowin) begin
      wb_valid <= MEM_signal_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_signal <= '0;
    end else if (MEM_signal_valid && WB_allowin) begin
      wb_signal <= MEM_signal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_wen) begin
      regs[rf_waddr] <= final_result;
    end
  end

  // Write-through bypass gives same-cycle visibility of the committing result
  function automatic logic [31:0] read_port(input logic [4:0] raddr);
    logic [31:0] data;
    data = '0;
    if (reset || raddr == 5'd0) begin
      data = '0;
    end else if (rf_wen && raddr == rf_waddr) begin
      data = final_result;
    end else begin
      data = regs[raddr];
    end
    return data;
  endfunction

  always_comb begin
    rf_rdata1 = read_port(rf_raddr1);
    rf_rdata2 = read_port(rf_raddr2);
  end

  always_comb begin
    WB_valid          = wb_live;
    WB_dest           = (wb_live && rf_we) ? rf_waddr : 5'd0;
    WB_wdata          = reset ? 32'd0 : final_result;
    debug_wb_pc       = reset ? 32'd0 : pc;
    debug_wb_rf_we    = {4{wb_live && rf_we}};
    debug_wb_rf_wnum  = reset ? 5'd0 : rf_waddr;
    debug_wb_rf_wdata = reset ? 32'd0 : final_result;
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, basic write, r0 protection, bubbles,
// back-to-back same-register writes and reset mid-stream.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        MEM_signal_valid;
  logic [69:0] MEM_signal;
  logic        WB_allowin;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        WB_valid;
  logic [4:0]  WB_dest;
  logic [31:0] WB_wdata;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  int checks;
  int errors;

  wb_stage dut (
    .clk              (clk),
    .reset            (reset),
    .MEM_signal_valid (MEM_signal_valid),
    .MEM_signal       (MEM_signal),
    .WB_allowin       (WB_allowin),
    .rf_raddr1        (rf_raddr1),
    .rf_raddr2        (rf_raddr2),
    .rf_rdata1        (rf_rdata1),
    .rf_rdata2        (rf_rdata2),
    .WB_valid         (WB_valid),
    .WB_dest          (WB_dest),
    .WB_wdata         (WB_wdata),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_we   (debug_wb_rf_we),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one MEM-side transfer at the falling edge; WB shows it after the next rising edge
  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic we,
                               input logic [4:0] waddr, input logic [31:0] data);
    @(negedge clk);
    MEM_signal_valid = valid;
    MEM_signal       = {pc, we, waddr, data};
    #1;
  endtask

  task automatic setRead(input logic [4:0] a1, input logic [4:0] a2);
    rf_raddr1 = a1;
    rf_raddr2 = a2;
    #1;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b1;
    MEM_signal_valid = 1'b1;
    MEM_signal       = '0;
    rf_raddr1        = 5'd0;
    rf_raddr2        = 5'd0;

    repeat (2) begin
      @(negedge clk);
      MEM_signal_valid = 1'($urandom());
      MEM_signal       = {6'($urandom()), $urandom(), $urandom()};
      #1;
      checkOutput("rst_valid", 32'(WB_valid), 32'd0);
      checkOutput("rst_trace_we", 32'(debug_wb_rf_we), 32'd0);
      checkOutput("rst_allowin", 32'(WB_allowin), 32'd0);
    end

    @(negedge clk);
    reset            = 1'b0;
    MEM_signal_valid = 1'b0;
    #1;
    checkOutput("post_rst_allowin", 32'(WB_allowin), 32'd1);
    for (int a = 1; a < 32; a += 5) begin
      setRead(5'(a), 5'(31 - a));
      checkOutput("post_rst_rdata1", rf_rdata1, 32'd0);
      checkOutput("post_rst_rdata2", rf_rdata2, 32'd0);
    end

    setRead(5'd5, 5'd5);
    applyStimulus(1'b1, 32'h1c000000, 1'b1, 5'd5, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("basic_trace_we", 32'(debug_wb_rf_we), 32'hf);
    checkOutput("basic_wnum", 32'(debug_wb_rf_wnum), 32'd5);
    checkOutput("basic_dest", 32'(WB_dest), 32'd5);
    checkOutput("basic_pc", debug_wb_pc, 32'h1c000000);
    checkOutput("basic_wdata", debug_wb_rf_wdata, 32'hDEADBEEF);
    checkOutput("basic_bypass", rf_rdata1, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("basic_bubble_valid", 32'(WB_valid), 32'd0);
    checkOutput("basic_stored", rf_rdata1, 32'hDEADBEEF);

    setRead(5'd0, 5'd0);
    applyStimulus(1'b1, 32'h1c000004, 1'b1, 5'd0, 32'h12345678);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("r0_trace_we", 32'(debug_wb_rf_we), 32'hf);
    checkOutput("r0_wnum", 32'(debug_wb_rf_wnum), 32'd0);
    checkOutput("r0_dest", 32'(WB_dest), 32'd0);
    checkOutput("r0_wb_wdata", WB_wdata, 32'h12345678);
    checkOutput("r0_read_same", rf_rdata1, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("r0_read_after", rf_rdata2, 32'd0);

    setRead(5'd5, 5'd5);
    applyStimulus(1'b1, 32'h1c000008, 1'b0, 5'd5, 32'h55555555);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("nowe_valid", 32'(WB_valid), 32'd1);
    checkOutput("nowe_trace_we", 32'(debug_wb_rf_we), 32'd0);
    checkOutput("nowe_dest", 32'(WB_dest), 32'd0);
    checkOutput("nowe_keep", rf_rdata1, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("bubble_valid", 32'(WB_valid), 32'd0);
    checkOutput("bubble_payload_hold", WB_wdata, 32'h55555555);
    checkOutput("bubble_keep", rf_rdata2, 32'hDEADBEEF);

    setRead(5'd7, 5'd7);
    applyStimulus(1'b1, 32'h1c00000c, 1'b1, 5'd7, 32'd1);
    applyStimulus(1'b1, 32'h1c000010, 1'b1, 5'd7, 32'd2);
    checkOutput("b2b_r7_1", rf_rdata2, 32'd1);
    checkOutput("b2b_port1_1", rf_rdata1, 32'd1);
    applyStimulus(1'b1, 32'h1c000014, 1'b1, 5'd7, 32'd3);
    checkOutput("b2b_r7_2", rf_rdata2, 32'd2);
    checkOutput("b2b_port1_2", rf_rdata1, 32'd2);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("b2b_r7_3", rf_rdata2, 32'd3);
    checkOutput("b2b_port1_3", rf_rdata1, 32'd3);
    checkOutput("b2b_trace_pc", debug_wb_pc, 32'h1c000014);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("b2b_final", rf_rdata2, 32'd3);
    checkOutput("b2b_final_port1", rf_rdata1, 32'd3);

    setRead(5'd9, 5'd7);
    applyStimulus(1'b1, 32'h1c000040, 1'b1, 5'd9, 32'hAA);
    @(negedge clk);
    reset            = 1'b1;
    MEM_signal_valid = 1'b0;
    #1;
    checkOutput("midrst_trace_we", 32'(debug_wb_rf_we), 32'd0);
    checkOutput("midrst_valid", 32'(WB_valid), 32'd0);
    checkOutput("midrst_allowin", 32'(WB_allowin), 32'd0);
    checkOutput("midrst_rdata", rf_rdata1, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrst_after_we", 32'(debug_wb_rf_we), 32'd0);
    checkOutput("midrst_after_pc", debug_wb_pc, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0);
    checkOutput("midrst_r9", rf_rdata1, 32'd0);
    checkOutput("midrst_r7", rf_rdata2, 32'd0);
    checkOutput("midrst_valid_after", 32'(WB_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
